// File: rtl/quick_spi_peripheral.sv
// ---------------------------------------------------------------------------
// quick_spi_peripheral
//   SPI peripheral (target) that oversamples the SPI pins with the system
//   clock. The initiator's SCLK idles high. Data is captured and shifted on
//   SCLK rising edges, MSB first. A single-word tx buffer feeds the next
//   frame. Completed rx frames are offered on a valid/ready port.
//
// Ports
//   clk_i          system clock (>= 8x SCLK frequency)
//   rst_i          synchronous active-high reset
//   tx_valid_i     tx_data_i holds a word for a future frame
//   tx_ready_o     tx buffer empty
//   tx_data_i      word to shift out, MSB first
//   rx_valid_o     rx_data_o / rx_len_o hold a completed frame
//   rx_ready_i     consumer accepts the held frame
//   rx_data_o      received bits, last-received bit at bit 0
//   rx_len_o       SCLK rising edges in the frame, saturating
//   rx_overflow_o  pulse: completed frame dropped, previous still held
//   tx_underrun_o  pulse: frame started with nothing to send
//   sclk_i         SPI clock from initiator
//   cs_n_i         active-low chip select
//   sdata_i        data from initiator
//   sdata_o        data to initiator
//   sdata_oe_o     drive enable for sdata_o
//
// State          | meaning
// ---------------+------------------------------------------------------
// ST_IDLE        | no frame; waiting for a cs_n falling edge
// ST_ACTIVE      | frame in progress; shifting on SCLK rising edges
// ST_WAIT_CS_HIGH| after reset; waiting for cs_n high before decoding
// ---------------------------------------------------------------------------
module quick_spi_peripheral #(
    parameter int MAX_DATA_LENGTH = 16,
    parameter int SYNC_STAGES     = 2,
    localparam int LEN_W          = $clog2(MAX_DATA_LENGTH + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    input  logic [MAX_DATA_LENGTH-1:0] tx_data_i,
    output logic                       rx_valid_o,
    input  logic                       rx_ready_i,
    output logic [MAX_DATA_LENGTH-1:0] rx_data_o,
    output logic [LEN_W-1:0]           rx_len_o,
    output logic                       rx_overflow_o,
    output logic                       tx_underrun_o,
    input  logic                       sclk_i,
    input  logic                       cs_n_i,
    input  logic                       sdata_i,
    output logic                       sdata_o,
    output logic                       sdata_oe_o
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ACTIVE       = 2'd1,
        ST_WAIT_CS_HIGH = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_DATA_LENGTH);
    // Cycles for a pin level present at reset release to reach the
    // synchronizer output; WAIT_CS_HIGH must not trust cs_n before then.
    localparam logic [1:0]       SETTLE  = 2'(SYNC_STAGES);

    state_t                     state;
    logic [1:0]                 settle_cnt;

    logic [SYNC_STAGES-1:0]     sclk_ff;
    logic [SYNC_STAGES-1:0]     cs_n_ff;
    logic [SYNC_STAGES-1:0]     sdata_ff;
    logic                       sclk_prev;
    logic                       cs_n_prev;

    logic                       sclk_s;
    logic                       cs_n_s;
    logic                       sdata_s;
    logic                       sclk_rise;
    logic                       cs_fall;
    logic                       cs_rise;

    logic [MAX_DATA_LENGTH-1:0] tx_buf;
    logic                       tx_full;
    logic [MAX_DATA_LENGTH-1:0] tx_sr;
    logic [MAX_DATA_LENGTH-1:0] rx_sr;
    logic [LEN_W-1:0]           rx_cnt;

    assign sclk_s    = sclk_ff[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_ff[SYNC_STAGES-1];
    assign sdata_s   = sdata_ff[SYNC_STAGES-1];
    assign sclk_rise = !sclk_prev && sclk_s;
    assign cs_fall   = cs_n_prev && !cs_n_s;
    assign cs_rise   = !cs_n_prev && cs_n_s;

    assign tx_ready_o = !tx_full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_WAIT_CS_HIGH;
            settle_cnt    <= SETTLE;
            sclk_ff       <= '1;
            cs_n_ff       <= '1;
            sdata_ff      <= '0;
            sclk_prev     <= 1'b1;
            cs_n_prev     <= 1'b1;
            tx_buf        <= '0;
            tx_full       <= 1'b0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            rx_cnt        <= '0;
            rx_valid_o    <= 1'b0;
            rx_data_o     <= '0;
            rx_len_o      <= '0;
            rx_overflow_o <= 1'b0;
            tx_underrun_o <= 1'b0;
            sdata_o       <= 1'b0;
            sdata_oe_o    <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk_i};
            cs_n_ff   <= {cs_n_ff[SYNC_STAGES-2:0], cs_n_i};
            sdata_ff  <= {sdata_ff[SYNC_STAGES-2:0], sdata_i};
            sclk_prev <= sclk_s;
            cs_n_prev <= cs_n_s;

            rx_overflow_o <= 1'b0;
            tx_underrun_o <= 1'b0;

            // Buffer fill; a frame start below may override tx_full.
            if (tx_valid_i && !tx_full) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end

            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            case (state)
                ST_WAIT_CS_HIGH: begin
                    if (settle_cnt != 2'd0) begin
                        settle_cnt <= settle_cnt - 2'd1;
                    end else if (cs_n_s) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (cs_fall) begin
                        state      <= ST_ACTIVE;
                        rx_cnt     <= '0;
                        rx_sr      <= '0;
                        sdata_oe_o <= 1'b1;
                        if (tx_full) begin
                            tx_sr   <= tx_buf;
                            tx_full <= 1'b0;
                            sdata_o <= tx_buf[MAX_DATA_LENGTH-1];
                        end else if (tx_valid_i) begin
                            // Word arriving on the start cycle goes straight
                            // to the shifter and never occupies the buffer.
                            tx_sr   <= tx_data_i;
                            tx_full <= 1'b0;
                            sdata_o <= tx_data_i[MAX_DATA_LENGTH-1];
                        end else begin
                            tx_sr         <= '0;
                            sdata_o       <= 1'b0;
                            tx_underrun_o <= 1'b1;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state      <= ST_IDLE;
                        sdata_o    <= 1'b0;
                        sdata_oe_o <= 1'b0;
                        if (rx_cnt != '0) begin
                            if (!rx_valid_o || rx_ready_i) begin
                                rx_data_o  <= rx_sr;
                                rx_len_o   <= rx_cnt;
                                rx_valid_o <= 1'b1;
                            end else begin
                                rx_overflow_o <= 1'b1;
                            end
                        end
                    end else if (sclk_rise) begin
                        rx_sr   <= {rx_sr[MAX_DATA_LENGTH-2:0], sdata_s};
                        tx_sr   <= {tx_sr[MAX_DATA_LENGTH-2:0], 1'b0};
                        sdata_o <= tx_sr[MAX_DATA_LENGTH-2];
                        if (rx_cnt != LEN_MAX) begin
                            rx_cnt <= rx_cnt + LEN_W'(1);
                        end
                    end
                end

                default: begin
                    state      <= ST_WAIT_CS_HIGH;
                    settle_cnt <= SETTLE;
                end
            endcase
        end
    end

endmodule

// File: doc/quick_spi_peripheral.md
QUICK_SPI_PERIPHERAL -- requirements
Module: quick_spi_peripheral

Interface
REQ-001 SHALL have parameter MAX_DATA_LENGTH, default 16: maximum bits per frame; legal range 2..64.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on sclk_i, cs_n_i and sdata_i; legal values 2..3.
REQ-003 SHALL have port clk_i  input  1  system clock; every flop in the block is clocked by it.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-005 SHALL have port tx_valid_i  input  1  tx_data_i holds a word for a future frame.
REQ-006 SHALL have port tx_ready_o  output  1  tx buffer empty; a word is accepted when tx_valid_i and tx_ready_o are both high.
REQ-007 SHALL have port tx_data_i  input  MAX_DATA_LENGTH  word to shift out, MSB first.
REQ-008 SHALL have port rx_valid_o  output  1  rx_data_o and rx_len_o hold a completed frame.
REQ-009 SHALL have port rx_ready_i  input  1  consumer accepts the frame when rx_ready_i and rx_valid_o are both high.
REQ-010 SHALL have port rx_data_o  output  MAX_DATA_LENGTH  received bits; the last-received bit is at bit 0.
REQ-011 SHALL have port rx_len_o  output  $clog2(MAX_DATA_LENGTH+1)  number of rising sclk edges in the frame, saturating at MAX_DATA_LENGTH.
REQ-012 SHALL have port rx_overflow_o  output  1  one-cycle pulse: a completed frame was dropped.
REQ-013 SHALL have port tx_underrun_o  output  1  one-cycle pulse: a frame started with the tx buffer empty.
REQ-014 SHALL have port sclk_i  input  1  SPI clock from the initiator; idles high.
REQ-015 SHALL have port cs_n_i  input  1  active-low chip select.
REQ-016 SHALL have port sdata_i  input  1  data from the initiator.
REQ-017 SHALL have port sdata_o  output  1  data to the initiator.
REQ-018 SHALL have port sdata_oe_o  output  1  drive enable for sdata_o; high only while a frame is active.

Function
REQ-019 SHALL pass sclk_i, cs_n_i and sdata_i through SYNC_STAGES flops; all edge detection uses the synchronized values (previous vs current); correct operation requires clk_i >= 8x sclk frequency.
REQ-020 SHALL implement the FSM states IDLE, ACTIVE and WAIT_CS_HIGH.
REQ-021 SHALL move IDLE->ACTIVE on a synchronized cs_n falling edge, ACTIVE->IDLE on a synchronized cs_n rising edge, and WAIT_CS_HIGH->IDLE when synchronized cs_n is high.
REQ-022 On the IDLE->ACTIVE cycle, SHALL load the tx shift register from the tx buffer and mark the buffer empty.
REQ-023 If the buffer is empty but tx_valid_i is high on the IDLE->ACTIVE cycle, SHALL load tx_data_i directly, count it as accepted, and leave the buffer empty.
REQ-024 Otherwise, when the buffer is empty at frame start, SHALL load all-zeros and pulse tx_underrun_o.
REQ-025 SHALL set the rx bit counter to 0 at frame start.
REQ-026 In ACTIVE, SHALL drive sdata_o from tx shift register MSB and hold sdata_oe_o high; outside ACTIVE, sdata_o=0 and sdata_oe_o=0.
REQ-027 On each synchronized sclk rising edge in ACTIVE, SHALL, in the same cycle: shift the synchronized sdata_i into rx shift register bit 0; shift the tx register left, filling with 0; increment the counter, saturating at MAX_DATA_LENGTH.
REQ-028 Frames longer than MAX_DATA_LENGTH SHALL keep the last MAX_DATA_LENGTH bits received.
REQ-029 SHALL ignore sclk edges outside ACTIVE.
REQ-030 On ACTIVE->IDLE with counter 0, SHALL produce no rx output.
REQ-031 On ACTIVE->IDLE with counter >0, if rx_valid_o is low or rx_ready_i is high that cycle, SHALL register rx_data_o and rx_len_o and set rx_valid_o the next cycle.
REQ-032 On ACTIVE->IDLE with counter >0 while a previous frame is still held, SHALL keep the held frame unchanged and pulse rx_overflow_o.
REQ-033 SHALL hold rx_valid_o high until a handshake, and keep rx_data_o and rx_len_o stable while rx_valid_o is high.
REQ-034 SHALL keep tx_ready_o low while the buffer is full; the buffer accepts at most one word.
REQ-035 SHALL ignore data accepted into the buffer during ACTIVE for the current frame; that data is used at the next frame start.

Reset
REQ-036 On rst_i high, SHALL set: tx_ready_o=1; rx_valid_o=0; rx_data_o=0; rx_len_o=0; rx_overflow_o=0; tx_underrun_o=0; sdata_o=0; sdata_oe_o=0.
REQ-037 On rst_i high, SHALL empty the tx buffer and clear the synchronizers to cs_n=1 and sclk=1.
REQ-038 On release of rst_i, SHALL enter WAIT_CS_HIGH, so a frame already in progress is never decoded.
REQ-039 Asserting rst_i mid-frame SHALL discard the frame without any pulse.

Verification
REQ-040 SHALL cover: preload tx 16'hA5C3; 16-bit frame with initiator sending 16'h1234 -> sdata_o bit sequence 1010010111000011; rx_data_o=16'h1234, rx_len_o=16, rx_valid_o held until rx_ready_i.
REQ-041 SHALL cover: 5-bit frame sending 10101, tx empty -> tx_underrun_o single pulse, sdata_o all 0; rx_data_o[4:0]=5'b10101, rx_len_o=5.
REQ-042 SHALL cover: two frames with rx_ready_i low -> first frame retained, rx_overflow_o pulses once at second CS rise.
REQ-043 SHALL cover: 20 rising edges with MAX_DATA_LENGTH=16 -> rx_len_o=16, rx_data_o = last 16 bits received.
REQ-044 SHALL cover: rst_i asserted at bit 7, released while cs_n_i low -> no rx_valid_o for that frame; next full frame decoded correctly.
REQ-045 SHALL cover: cs_n pulse with no sclk edges -> no rx_valid_o; tx buffer consumed.
